// File: rtl/port_dec_reg_if.sv
// rtl/port_dec_reg_if.sv - processor port bus between CPU, port decoder and UART register blocks
interface port_dec_reg_if #(
  parameter int N_CH   = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic                     write_strobe;
  logic                     read_strobe;
  logic [15:0]              pid;
  logic [DATA_W-1:0]        out_port;
  logic [N_CH*DATA_W-1:0]   rd_data;
  logic                     err_clr;
  logic [N_CH-1:0]          writes;
  logic [N_CH-1:0]          reads;
  logic [DATA_W-1:0]        wr_data;
  logic [DATA_W-1:0]        in_port;
  logic                     err;
  logic [CNT_W-1:0]         err_cnt;

  modport master (
    output write_strobe, read_strobe, pid, out_port, rd_data, err_clr,
    input  writes, reads, wr_data, in_port, err, err_cnt
  );

  modport slave (
    input  write_strobe, read_strobe, pid, out_port, rd_data, err_clr,
    output writes, reads, wr_data, in_port, err, err_cnt
  );
endinterface

// File: rtl/port_dec_reg.sv
// rtl/port_dec_reg.sv - registered one-hot I/O port decoder; PORT_DEC_ERR_EN builds err/err_cnt
module port_dec_reg #(
  parameter int          N_CH   = 8,
  parameter logic [15:0] BASE   = 16'h0000,
  parameter int          DATA_W = 8,
  parameter int          CNT_W  = 8
) (
  input logic           clk,
  input logic           rst_n,
  port_dec_reg_if.slave bus
);
  localparam int AW = $clog2(N_CH);

  typedef enum logic {IDLE, HELD} st_t;

  st_t               wr_st;
  st_t               rd_st;
  logic              hit;
  logic [AW-1:0]     ch;
  logic [N_CH-1:0]   ch_sel;
  logic [DATA_W-1:0] rd_mux;
  logic              wr_edge;
  logic              rd_edge;

  assign hit     = (bus.pid[15:AW] == BASE[15:AW]);
  assign ch      = bus.pid[AW-1:0];
  assign ch_sel  = N_CH'(1) << ch;
  assign rd_mux  = bus.rd_data[ch*DATA_W +: DATA_W];
  assign wr_edge = (wr_st == IDLE) && bus.write_strobe;
  assign rd_edge = (rd_st == IDLE) && bus.read_strobe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_st       <= IDLE;
      rd_st       <= IDLE;
      bus.writes  <= '0;
      bus.reads   <= '0;
      bus.wr_data <= '0;
      bus.in_port <= '0;
    end else begin
      case (wr_st)
        IDLE:    if (bus.write_strobe) wr_st <= HELD;
        default: if (!bus.write_strobe) wr_st <= IDLE;
      endcase
      case (rd_st)
        IDLE:    if (bus.read_strobe) rd_st <= HELD;
        default: if (!bus.read_strobe) rd_st <= IDLE;
      endcase
      // a simultaneous write edge always swallows the read pulse
      bus.writes  <= (wr_edge && hit) ? ch_sel : '0;
      bus.reads   <= (rd_edge && !wr_edge && hit) ? ch_sel : '0;
      if (wr_edge && hit) bus.wr_data <= bus.out_port;
      bus.in_port <= hit ? rd_mux : '0;
    end
  end

`ifdef PORT_DEC_ERR_EN
  logic ev;

  // collision and unmapped in the same cycle still count as a single event
  assign ev = (wr_edge || rd_edge) && (!hit || (wr_edge && rd_edge));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.err     <= 1'b0;
      bus.err_cnt <= '0;
    end else if (ev) begin
      bus.err <= 1'b1;
      if (bus.err_clr)
        bus.err_cnt <= CNT_W'(1);
      else if (bus.err_cnt != '1)
        bus.err_cnt <= bus.err_cnt + 1'b1;
    end else if (bus.err_clr) begin
      bus.err     <= 1'b0;
      bus.err_cnt <= '0;
    end
  end
`else
  logic unused_err_clr;

  assign unused_err_clr = bus.err_clr;
  assign bus.err        = 1'b0;
  assign bus.err_cnt    = '0;
`endif
endmodule

// File: doc/port_dec_reg.md
# port_dec_reg

Parametrised, registered I/O-port decoder for the UART controller's processor port bus. It turns `write_strobe`/`read_strobe` plus `pid` into one-cycle, one-hot channel pulses for `N_CH` channels placed at a configurable base address. It also registers write data and multiplexes per-channel read data back to the processor, and tracks illegal accesses (unmapped port, read/write collision) in a sticky flag and a saturating counter. It sits between the processor port bus and the UART register/FIFO blocks.

## Interface
- `N_CH`, 8: channel count; power of two, 2..32. `AW = log2(N_CH)`.
- `BASE`, 16'h0000: base port address; low `AW` bits must be zero.
- `DATA_W`, 8: port data width.
- `CNT_W`, 8: error counter width.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `write_strobe`  in  1  processor output strobe.
- `read_strobe`  in  1  processor input strobe.
- `pid`  in  16  port address.
- `out_port`  in  DATA_W  processor write data.
- `rd_data`  in  N_CH*DATA_W  per-channel read data; channel k occupies bits [k*DATA_W +: DATA_W].
- `err_clr`  in  1  clears `err` and `err_cnt`.
- `writes`  out  N_CH  one-hot write pulses.
- `reads`  out  N_CH  one-hot read pulses.
- `wr_data`  out  DATA_W  registered write data.
- `in_port`  out  DATA_W  registered read data to processor.
- `err`  out  1  sticky illegal-access flag.
- `err_cnt`  out  CNT_W  saturating illegal-access count.

## Operation
- `hit = (pid[15:AW] == BASE[15:AW])`.
- `ch = pid[AW-1:0]`.
- Strobe qualification uses a two-state FSM per strobe (IDLE, HELD).
  - IDLE→HELD on strobe=1. A pulse is generated on this transition only.
  - HELD→IDLE on strobe=0.
  - A strobe held high for any number of cycles yields exactly one pulse. A change of `pid` while HELD yields no new pulse.
- Write edge with `hit`:
  - `writes[ch]` pulses for one cycle.
  - `wr_data <= out_port`.
  - `wr_data` otherwise holds its value.
- Read edge with `hit`: `reads[ch]` pulses for one cycle.
- Write edge and read edge in the same cycle (collision):
  - The write is issued.
  - The read pulse is suppressed.
  - One error event is logged.
- An edge with `!hit` produces no pulse and logs one error event. A collision that is also unmapped logs one event total.
- `in_port` updates every cycle:
  - `hit`: `in_port <= rd_data[ch]`.
  - `!hit`: `in_port <= 0`.
- Error event handling:
  - Each event sets `err=1`.
  - Each event increments `err_cnt`, saturating at all-ones.
- `err_clr=1` without an event: `err<=0`, `err_cnt<=0`.
- `err_clr=1` with an event in the same cycle: event wins, `err<=1`, `err_cnt<=1`.
- Reset mid-operation aborts any pulse. All state returns to reset values. Both FSMs return to IDLE, so a strobe already high when `rst_n` releases produces one pulse.

## Timing
- Reset values:
  - `writes=0`, `reads=0`, `wr_data=0`, `in_port=0`, `err=0`, `err_cnt=0`.
  - Both FSMs in IDLE.
- Strobe latency: strobe rising at edge n → pulse high for exactly the cycle following edge n (latency 1). Pulse width is always 1 cycle.
- Back-to-back strobes (high, low, high) produce pulses two cycles apart.
- `in_port` latency is 1 cycle from `pid`/`rd_data`. The processor samples `in_port` no earlier than one cycle after presenting `pid`.
- `wr_data` is valid in the same cycle as its `writes` pulse.
- `err`/`err_cnt` update one cycle after the offending strobe edge.

## Configuration
- `PORT_DEC_ERR_EN` defined: error-event logic, `err` and `err_cnt` are built as specified.
- `PORT_DEC_ERR_EN` undefined:
  - `err` and `err_cnt` are constant 0.
  - `err_clr` is ignored.
  - Decode and collision resolution (write wins, read suppressed) are unchanged.

## Test plan
- Reset, then write edge: N_CH=8, BASE=16'h0010, pid=16'h0013, out_port=8'hA5, single-cycle write_strobe → `writes=8'b0000_1000` for one cycle, `wr_data=8'hA5`, `err=0`.
- Read decode: pid=16'h0016, rd_data channel 6 = 8'h3C, read_strobe held high 5 cycles → `reads=8'b0100_0000` exactly once; `in_port=8'h3C` from one cycle after `pid` is applied.
- Unmapped access: pid=16'h0020, write_strobe pulsed 3 times (low between pulses) → no `writes` pulse; `err=1`, `err_cnt=3`.
- Collision: write_strobe and read_strobe rise together at pid=16'h0011 → `writes[1]` pulses, no `reads` pulse, `err_cnt` +1.
- Saturation and clear: CNT_W=2, 5 unmapped edges → `err_cnt=2'b11`; `err_clr` in the same cycle as a new event → `err=1`, `err_cnt=1`; `err_clr` alone → both 0.
- Async reset: assert `rst_n=0` mid-pulse with write_strobe held high → outputs 0 immediately; on release with strobe still high → exactly one `writes` pulse. Rerun without `PORT_DEC_ERR_EN` → `err`/`err_cnt` stay 0 throughout.
